alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits.
REQ-002 clk  input  1  rising-edge clock for all output registers.
REQ-003 reset  input  1  asynchronous, active-high reset; clears all output registers.
REQ-004 alu_control  input  4  operation select.
REQ-005 alu_AI  input  8  operand A (accumulator side).
REQ-006 alu_BI  input  8  operand B (memory/immediate side).
REQ-007 alu_carry_in  input  1  carry/borrow-not in; rotate fill bit.
REQ-008 alu_decimal  input  1  BCD mode request for ADD/SUB; used only when ALU_BCD_EN is defined.
REQ-009 alu_Y  output  8  registered result.
REQ-010 alu_carry_out  output  1  registered carry out.
REQ-011 alu_overflow  output  1  registered signed overflow.
REQ-012 alu_zero  output  1  registered, high when alu_Y == 0x00.
REQ-013 alu_negative  output  1  registered copy of alu_Y[7].

Function
REQ-014 Inputs sampled on rising clk; all outputs update together; latency exactly 1 cycle; new operation accepted every cycle; no handshake.
REQ-015 Encoding: 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 ASL, 0x6 LSR, 0x7 ROL, 0x8 ROR, 0x9 INC, 0xA DEC, 0xB PASS; 0xC-0xF reserved.
REQ-016 ADD: {C,Y} = A + B + Cin (9-bit); V = (A7 == B7) && (Y7 != A7).
REQ-017 SUB: {C,Y} = A + ~B + Cin; C = 1 means no borrow; V = (A7 != B7) && (Y7 != A7).
REQ-018 AND/OR/XOR: Y = bitwise A op B; C = 0; V = 0.
REQ-019 ASL: Y = {A[6:0],0}, C = A7; LSR: Y = {0,A[7:1]}, C = A0; V = 0.
REQ-020 ROL: Y = {A[6:0],Cin}, C = A7; ROR: Y = {Cin,A[7:1]}, C = A0; V = 0.
REQ-021 INC: Y = A + 1 mod 256; DEC: Y = A - 1 mod 256; C = 0, V = 0; 0xFF INC wraps to 0x00; 0x00 DEC wraps to 0xFF.
REQ-022 PASS: Y = A; C = 0; V = 0.
REQ-023 Reserved codes: Y = 0x00, C = 0, V = 0, Z = 1, N = 0.
REQ-024 Z and N always derived from the final registered Y, including BCD-adjusted results.
REQ-025 Operand B ignored for all single-operand operations (ASL, LSR, ROL, ROR, INC, DEC, PASS).

Reset
REQ-026 While reset is high: alu_Y = 0x00, alu_carry_out = 0, alu_overflow = 0, alu_zero = 1, alu_negative = 0, taking effect immediately without a clock edge.
REQ-027 Reset asserted mid-operation discards the pending result; the first result after deassertion comes from inputs sampled on the first rising edge with reset low.

Configuration
REQ-028 Macro ALU_BCD_EN defined: with alu_decimal = 1, ADD/SUB treat operands as packed BCD; each nibble is decimal-adjusted; ADD C = 1 when the decimal sum > 99; SUB C = 0 on decimal borrow; V is computed from the binary (unadjusted) result.
REQ-029 ALU_BCD_EN undefined: alu_decimal port remains present but is ignored; all arithmetic is binary.

Verification
REQ-030 ADD A=0x50 B=0x50 Cin=0 -> next cycle Y=0xA0, C=0, V=1, N=1, Z=0.
REQ-031 ADD A=0xFF B=0x01 Cin=0 -> Y=0x00, C=1, V=0, Z=1.
REQ-032 SUB A=0x50 B=0xB0 Cin=1 -> Y=0xA0, C=0, V=1.
REQ-033 ROR A=0x01 Cin=1 -> Y=0x80, C=1, N=1; INC A=0xFF -> Y=0x00, Z=1.
REQ-034 ALU_BCD_EN defined, decimal=1, ADD A=0x58 B=0x46 Cin=1 -> Y=0x05, C=1; macro undefined with same stimulus -> Y=0x9F, C=0.
REQ-035 Reset asserted between clock edges after a nonzero result -> outputs go to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/control and result/flag bundle for the 8-bit alu
interface alu_if;
  logic [3:0] alu_control;
  logic [7:0] alu_AI;
  logic [7:0] alu_BI;
  logic       alu_carry_in;
  logic       alu_decimal;
  logic [7:0] alu_Y;
  logic       alu_carry_out;
  logic       alu_overflow;
  logic       alu_zero;
  logic       alu_negative;

  modport master (
    output alu_control, alu_AI, alu_BI, alu_carry_in, alu_decimal,
    input  alu_Y, alu_carry_out, alu_overflow, alu_zero, alu_negative
  );

  modport slave (
    input  alu_control, alu_AI, alu_BI, alu_carry_in, alu_decimal,
    output alu_Y, alu_carry_out, alu_overflow, alu_zero, alu_negative
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit registered alu, one-cycle latency; packed-BCD add/sub when ALU_BCD_EN is defined
module alu (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_ASL  = 4'h5,
    OP_LSR  = 4'h6,
    OP_ROL  = 4'h7,
    OP_ROR  = 4'h8,
    OP_INC  = 4'h9,
    OP_DEC  = 4'hA,
    OP_PASS = 4'hB
  } alu_op_e;

  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [8:0] sum_bin;
  logic [8:0] diff_bin;
  logic       v_add;
  logic       v_sub;
  logic [7:0] y_next;
  logic       c_next;
  logic       v_next;

  assign a   = bus.alu_AI;
  assign b   = bus.alu_BI;
  assign cin = bus.alu_carry_in;

  assign sum_bin  = {1'b0, a} + {1'b0, b}  + {8'b0, cin};
  assign diff_bin = {1'b0, a} + {1'b0, ~b} + {8'b0, cin};

  // Overflow always comes from the binary result, even in decimal mode.
  assign v_add = (a[7] == b[7]) && (sum_bin[7]  != a[7]);
  assign v_sub = (a[7] != b[7]) && (diff_bin[7] != a[7]);

`ifdef ALU_BCD_EN
  logic       decimal_mode;
  logic [4:0] lo_add;
  logic       half_carry;
  logic [4:0] lo_add_adj;
  logic [4:0] hi_add;
  logic       dec_carry;
  logic [4:0] hi_add_adj;
  logic [4:0] lo_sub;
  logic       lo_borrow;
  logic [3:0] lo_sub_adj;
  logic [4:0] hi_sub;
  logic       hi_borrow;
  logic [3:0] hi_sub_adj;
  logic [7:0] bcd_sum;
  logic [7:0] bcd_diff;

  assign decimal_mode = bus.alu_decimal;

  assign lo_add     = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign half_carry = (lo_add > 5'd9);
  assign lo_add_adj = half_carry ? (lo_add + 5'd6) : lo_add;
  assign hi_add     = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, half_carry};
  assign dec_carry  = (hi_add > 5'd9);
  assign hi_add_adj = dec_carry ? (hi_add + 5'd6) : hi_add;
  assign bcd_sum    = {hi_add_adj[3:0], lo_add_adj[3:0]};

  // Borrow-in is the inverse of carry-in; a negative nibble needs a -6 fixup.
  assign lo_sub     = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, ~cin};
  assign lo_borrow  = lo_sub[4];
  assign lo_sub_adj = lo_borrow ? (lo_sub[3:0] - 4'd6) : lo_sub[3:0];
  assign hi_sub     = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'b0, lo_borrow};
  assign hi_borrow  = hi_sub[4];
  assign hi_sub_adj = hi_borrow ? (hi_sub[3:0] - 4'd6) : hi_sub[3:0];
  assign bcd_diff   = {hi_sub_adj, lo_sub_adj};
`else
  logic unused_decimal;
  assign unused_decimal = bus.alu_decimal;
`endif

  always_comb begin
    y_next = 8'h00;
    c_next = 1'b0;
    v_next = 1'b0;
    case (bus.alu_control)
      OP_ADD: begin
`ifdef ALU_BCD_EN
        if (decimal_mode) begin
          y_next = bcd_sum;
          c_next = dec_carry;
        end else begin
          y_next = sum_bin[7:0];
          c_next = sum_bin[8];
        end
`else
        y_next = sum_bin[7:0];
        c_next = sum_bin[8];
`endif
        v_next = v_add;
      end
      OP_SUB: begin
`ifdef ALU_BCD_EN
        if (decimal_mode) begin
          y_next = bcd_diff;
          c_next = ~hi_borrow;
        end else begin
          y_next = diff_bin[7:0];
          c_next = diff_bin[8];
        end
`else
        y_next = diff_bin[7:0];
        c_next = diff_bin[8];
`endif
        v_next = v_sub;
      end
      OP_AND:  y_next = a & b;
      OP_OR:   y_next = a | b;
      OP_XOR:  y_next = a ^ b;
      OP_ASL: begin
        y_next = {a[6:0], 1'b0};
        c_next = a[7];
      end
      OP_LSR: begin
        y_next = {1'b0, a[7:1]};
        c_next = a[0];
      end
      OP_ROL: begin
        y_next = {a[6:0], cin};
        c_next = a[7];
      end
      OP_ROR: begin
        y_next = {cin, a[7:1]};
        c_next = a[0];
      end
      OP_INC:  y_next = a + 8'd1;
      OP_DEC:  y_next = a - 8'd1;
      OP_PASS: y_next = a;
      default: y_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alu_Y         <= 8'h00;
      bus.alu_carry_out <= 1'b0;
      bus.alu_overflow  <= 1'b0;
      bus.alu_zero      <= 1'b1;
      bus.alu_negative  <= 1'b0;
    end else begin
      bus.alu_Y         <= y_next;
      bus.alu_carry_out <= c_next;
      bus.alu_overflow  <= v_next;
      bus.alu_zero      <= (y_next == 8'h00);
      bus.alu_negative  <= y_next[7];
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed-vector self-checking bench for alu
module tb_alu;
  logic clk;
  logic reset;
  int   passed;
  int   total;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [7:0] y, input logic c,
                           input logic v, input logic z, input logic n);
    check({tag, ".y"}, bus.alu_Y, y);
    check({tag, ".c"}, {7'b0, bus.alu_carry_out}, {7'b0, c});
    check({tag, ".v"}, {7'b0, bus.alu_overflow},  {7'b0, v});
    check({tag, ".z"}, {7'b0, bus.alu_zero},      {7'b0, z});
    check({tag, ".n"}, {7'b0, bus.alu_negative},  {7'b0, n});
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic dec);
    bus.alu_control  = op;
    bus.alu_AI       = a;
    bus.alu_BI       = b;
    bus.alu_carry_in = cin;
    bus.alu_decimal  = dec;
  endtask

  // Called at a negedge: drive, let one rising edge pass, check at the next negedge.
  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic cin, input logic dec,
                     input logic [7:0] y, input logic c, input logic v,
                     input logic z, input logic n);
    drive(op, a, b, cin, dec);
    @(negedge clk);
    check_all(tag, y, c, v, z, n);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    drive(4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_all("reset_init", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run("add_v",     4'h0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
    run("add_wrap",  4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run("sub_v",     4'h1, 8'h50, 8'hB0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
    run("sub_plain", 4'h1, 8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    run("and",       4'h2, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    run("or",        4'h3, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run("xor",       4'h4, 8'hAA, 8'hFF, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    run("asl",       4'h5, 8'h81, 8'hFF, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    run("lsr",       4'h6, 8'h01, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run("rol",       4'h7, 8'h80, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    run("ror",       4'h8, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    run("inc_wrap",  4'h9, 8'hFF, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    run("dec_wrap",  4'hA, 8'h00, 8'h55, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run("pass",      4'hB, 8'h7F, 8'hFF, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    run("rsvd_c",    4'hC, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    run("rsvd_f",    4'hF, 8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ALU_BCD_EN
    run("dec_add",   4'h0, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
    run("dec_sub",   4'h1, 8'h42, 8'h13, 1'b1, 1'b1, 8'h29, 1'b1, 1'b0, 1'b0, 1'b0);
    run("dec_sub_b", 4'h1, 8'h10, 8'h20, 1'b1, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    run("dec_add",   4'h0, 8'h58, 8'h46, 1'b1, 1'b1, 8'h9F, 1'b0, 1'b1, 1'b0, 1'b1);
    run("dec_sub",   4'h1, 8'h42, 8'h13, 1'b1, 1'b1, 8'h2F, 1'b1, 1'b0, 1'b0, 1'b0);
    run("dec_sub_b", 4'h1, 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    run("bin_add_d0", 4'h0, 8'h58, 8'h46, 1'b1, 1'b0, 8'h9F, 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges, with a pending operation that must be dropped.
    run("pre_rst",   4'h0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'hB, 8'h33, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_all("rst_async", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_all("rst_hold", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    run("post_rst",  4'hB, 8'h33, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
